alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_opcode  input  6  MIPS opcode field.
REQ-007 req_funct  input  6  MIPS funct field, used only when req_opcode = 0.
REQ-008 req_a, req_b  input  WIDTH each  signed operands (rs value; rt value or immediate).
REQ-009 alu_a, alu_b  output  WIDTH each  registered operands driven to the combinational ALU.
REQ-010 alu_function  output  3  registered ALU op code: ADD=0, SUB=1, AND=2, OR=3, XOR=4.
REQ-011 alu_result  input  WIDTH  ALU result.
REQ-012 alu_is_zero, alu_is_sign, alu_is_ovf  input  1 each  ALU flags.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_result  output  WIDTH  captured result.
REQ-016 rsp_zero, rsp_sign, rsp_ovf  output  1 each  captured flags.
REQ-017 rsp_branch_taken  output  1  branch decision for BEQ/BNE.
REQ-018 rsp_illegal  output  1  undecodable request.
REQ-019 ovf_count  output  8  saturating count of responses with rsp_ovf=1.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, EXEC and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on a clk edge where req_valid & req_ready.
REQ-022 On acceptance of a legal request the block SHALL register req_a, req_b and the decoded op onto alu_a, alu_b, alu_function and move to EXEC.
REQ-023 Decode SHALL be: opcode 0 with funct 0x20/0x22/0x24/0x25/0x26 -> ADD/SUB/AND/OR/XOR; 0x08 ADDI -> ADD; 0x0C ANDI -> AND; 0x0D ORI -> OR; 0x0E XORI -> XOR; 0x04 BEQ and 0x05 BNE -> SUB.
REQ-024 Any other opcode/funct SHALL be illegal: no EXEC; go directly to RESP with rsp_illegal=1, rsp_result=0, all flags 0, rsp_branch_taken=0; alu_* unchanged.
REQ-025 In EXEC (one cycle), the block SHALL capture alu_result and the flags into the rsp_* registers at the next edge and move to RESP.
REQ-026 rsp_ovf SHALL equal alu_is_ovf for ADD/SUB and be forced to 0 for AND/OR/XOR.
REQ-027 rsp_branch_taken SHALL be alu_is_zero for BEQ, !alu_is_zero for BNE, and 0 for all other ops.
REQ-028 Latency: rsp_valid SHALL rise exactly 2 cycles after the acceptance edge for legal requests and 1 cycle after it for illegal ones.
REQ-029 In RESP, rsp_valid=1 and all rsp_* SHALL hold stable until an edge with rsp_ready=1, after which the state SHALL be IDLE.
REQ-030 rsp_valid SHALL be 0 in IDLE and EXEC; no request is accepted in the same cycle a response is consumed.
REQ-031 ovf_count SHALL increment by 1 on each response handshake with rsp_ovf=1 and saturate at 255 (no wrap).
REQ-032 rsp_illegal responses SHALL never change ovf_count.

Reset
REQ-033 While reset=1 at a clk edge, the state SHALL become IDLE and alu_a, alu_b, alu_function, all rsp_* outputs and ovf_count SHALL become 0.
REQ-034 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response handshake.
REQ-035 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-036 A shared package alu_pkg SHALL hold the ALU function codes, the opcode/funct constants and the state enumeration.
REQ-037 A combinational sub-module alu_decode SHALL map opcode/funct to alu_function, illegal and branch kind (none/BEQ/BNE).
REQ-038 The ALU SHALL be instantiated outside alu_issue; alu_issue connects only through the alu_* ports.

Verification
REQ-039 ADD funct 0x20, a=100, b=27 -> rsp_valid 2 cycles later, rsp_result=127, zero=0, sign=0, ovf=0.
REQ-040 ADDI a=100, b=28 -> rsp_result=-128 (0x80), sign=1, ovf=1, ovf_count=1 after handshake.
REQ-041 BEQ a=5, b=5 -> branch_taken=1, zero=1; BNE a=5, b=5 -> branch_taken=0.
REQ-042 opcode 0x3F -> rsp_valid 1 cycle after accept, rsp_illegal=1, result 0, ovf_count unchanged.
REQ-043 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0 throughout; reset asserted mid-EXEC -> IDLE, rsp_valid=0, ovf_count=0.
REQ-044 256 overflowing ADDs (a=127, b=1) -> ovf_count=255, unchanged on further overflows.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue block: ALU function codes, MIPS
// opcode/funct constants, FSM states and branch kinds.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2
  } br_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [7:0] OVF_COUNT_MAX = 8'hFF;

  // Only ADD/SUB produce a meaningful overflow flag.
  function automatic logic is_arith(input alu_func_e f);
    return (f == ALU_ADD) || (f == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request/response and ALU-side signals of the ALU issue block.
// slave = issue block, master = requester plus the external ALU.
interface alu_issue_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_opcode;
  logic [5:0]       req_funct;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_function;
  logic [WIDTH-1:0] alu_result;
  logic             alu_is_zero;
  logic             alu_is_sign;
  logic             alu_is_ovf;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_sign;
  logic             rsp_ovf;
  logic             rsp_branch_taken;
  logic             rsp_illegal;
  logic [7:0]       ovf_count;

  modport slave (
    input  req_valid, req_opcode, req_funct, req_a, req_b,
    input  alu_result, alu_is_zero, alu_is_sign, alu_is_ovf,
    input  rsp_ready,
    output req_ready, alu_a, alu_b, alu_function,
    output rsp_valid, rsp_result, rsp_zero, rsp_sign, rsp_ovf,
    output rsp_branch_taken, rsp_illegal, ovf_count
  );

  modport master (
    output req_valid, req_opcode, req_funct, req_a, req_b,
    output alu_result, alu_is_zero, alu_is_sign, alu_is_ovf,
    output rsp_ready,
    input  req_ready, alu_a, alu_b, alu_function,
    input  rsp_valid, rsp_result, rsp_zero, rsp_sign, rsp_ovf,
    input  rsp_branch_taken, rsp_illegal, ovf_count
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational MIPS opcode/funct decoder: ALU function, illegal flag and
// branch kind.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_func_e  alu_function,
  output logic       illegal,
  output br_kind_e   br_kind
);

  // Decode table; anything not listed is illegal.
  always_comb begin
    alu_function = ALU_ADD;
    illegal      = 1'b0;
    br_kind      = BR_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_function = ALU_ADD;
          FN_SUB:  alu_function = ALU_SUB;
          FN_AND:  alu_function = ALU_AND;
          FN_OR:   alu_function = ALU_OR;
          FN_XOR:  alu_function = ALU_XOR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: alu_function = ALU_ADD;
      OP_ANDI: alu_function = ALU_AND;
      OP_ORI:  alu_function = ALU_OR;
      OP_XORI: alu_function = ALU_XOR;
      OP_BEQ: begin
        alu_function = ALU_SUB;
        br_kind      = BR_BEQ;
      end
      OP_BNE: begin
        alu_function = ALU_SUB;
        br_kind      = BR_BNE;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Single-issue front end for an external combinational ALU: decodes a MIPS
// request, drives registered operands, captures the result and flags.
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);

  alu_func_e        dec_func_s;
  logic             dec_illegal_s;
  br_kind_e         dec_br_s;

  state_e           state_r;
  br_kind_e         br_kind_r;
  logic             req_ready_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  alu_func_e        alu_function_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic             rsp_zero_r;
  logic             rsp_sign_r;
  logic             rsp_ovf_r;
  logic             rsp_branch_r;
  logic             rsp_illegal_r;
  logic [7:0]       ovf_count_r;

  logic             ovf_s;
  logic             branch_s;

  alu_decode u_decode (
    .opcode       (bus.req_opcode),
    .funct        (bus.req_funct),
    .alu_function (dec_func_s),
    .illegal      (dec_illegal_s),
    .br_kind      (dec_br_s)
  );

  // Flag qualification of the live ALU outputs for the in-flight op.
  always_comb begin
    ovf_s    = 1'b0;
    branch_s = 1'b0;
    if (is_arith(alu_function_r)) begin
      ovf_s = bus.alu_is_ovf;
    end else begin
      ovf_s = 1'b0;
    end
    case (br_kind_r)
      BR_BEQ:  branch_s = bus.alu_is_zero;
      BR_BNE:  branch_s = ~bus.alu_is_zero;
      default: branch_s = 1'b0;
    endcase
  end

  // Issue FSM: accept in IDLE, sample the ALU in EXEC, hold the response in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      br_kind_r      <= BR_NONE;
      req_ready_r    <= 1'b1;
      alu_a_r        <= '0;
      alu_b_r        <= '0;
      alu_function_r <= ALU_ADD;
      rsp_valid_r    <= 1'b0;
      rsp_result_r   <= '0;
      rsp_zero_r     <= 1'b0;
      rsp_sign_r     <= 1'b0;
      rsp_ovf_r      <= 1'b0;
      rsp_branch_r   <= 1'b0;
      rsp_illegal_r  <= 1'b0;
      ovf_count_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_r <= 1'b0;
            if (dec_illegal_s) begin
              // Illegal requests bypass the ALU and leave alu_* untouched.
              rsp_result_r  <= '0;
              rsp_zero_r    <= 1'b0;
              rsp_sign_r    <= 1'b0;
              rsp_ovf_r     <= 1'b0;
              rsp_branch_r  <= 1'b0;
              rsp_illegal_r <= 1'b1;
              rsp_valid_r   <= 1'b1;
              state_r       <= RESP;
            end else begin
              alu_a_r        <= bus.req_a;
              alu_b_r        <= bus.req_b;
              alu_function_r <= dec_func_s;
              br_kind_r      <= dec_br_s;
              state_r        <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_result_r  <= bus.alu_result;
          rsp_zero_r    <= bus.alu_is_zero;
          rsp_sign_r    <= bus.alu_is_sign;
          rsp_ovf_r     <= ovf_s;
          rsp_branch_r  <= branch_s;
          rsp_illegal_r <= 1'b0;
          rsp_valid_r   <= 1'b1;
          state_r       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
            if (rsp_ovf_r && (ovf_count_r != OVF_COUNT_MAX)) begin
              ovf_count_r <= ovf_count_r + 8'd1;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_r;
  assign bus.alu_a            = alu_a_r;
  assign bus.alu_b            = alu_b_r;
  assign bus.alu_function     = alu_function_r;
  assign bus.rsp_valid        = rsp_valid_r;
  assign bus.rsp_result       = rsp_result_r;
  assign bus.rsp_zero         = rsp_zero_r;
  assign bus.rsp_sign         = rsp_sign_r;
  assign bus.rsp_ovf          = rsp_ovf_r;
  assign bus.rsp_branch_taken = rsp_branch_r;
  assign bus.rsp_illegal      = rsp_illegal_r;
  assign bus.ovf_count        = ovf_count_r;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, reset and
// saturation sequences, and randomized requests against a reference model.
module tb_alu_issue;

  localparam int W = 8;

  typedef struct {
    logic [7:0] result;
    logic       zero;
    logic       sign;
    logic       ovf;
    logic       br;
    logic       ill;
    logic [2:0] func;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   exp_cnt;
  logic [7:0] last_a;
  logic [7:0] last_b;
  logic [2:0] last_f;
  int   alu_r;

  alu_issue_if #(.WIDTH(W)) bus ();

  alu_issue #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; logic ops deliberately report a bogus overflow.
  always_comb begin
    alu_r = 0;
    bus.alu_is_ovf = 1'b0;
    case (bus.alu_function)
      3'd0: begin
        alu_r = $signed(bus.alu_a) + $signed(bus.alu_b);
        bus.alu_is_ovf = (alu_r > 127) || (alu_r < -128);
      end
      3'd1: begin
        alu_r = $signed(bus.alu_a) - $signed(bus.alu_b);
        bus.alu_is_ovf = (alu_r > 127) || (alu_r < -128);
      end
      3'd2: begin alu_r = int'(bus.alu_a & bus.alu_b); bus.alu_is_ovf = 1'b1; end
      3'd3: begin alu_r = int'(bus.alu_a | bus.alu_b); bus.alu_is_ovf = 1'b1; end
      3'd4: begin alu_r = int'(bus.alu_a ^ bus.alu_b); bus.alu_is_ovf = 1'b1; end
      default: begin alu_r = 0; bus.alu_is_ovf = 1'b0; end
    endcase
    bus.alu_result  = alu_r[7:0];
    bus.alu_is_zero = (alu_r[7:0] == 8'd0);
    bus.alu_is_sign = alu_r[7];
  end

  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int kind;
    int br;
    int sa;
    int sb;
    int r;
    kind = -1;
    br = 0;
    sa = $signed(a);
    sb = $signed(b);
    r = 0;
    if (op == 6'h00) begin
      if (fn == 6'h20) kind = 0;
      else if (fn == 6'h22) kind = 1;
      else if (fn == 6'h24) kind = 2;
      else if (fn == 6'h25) kind = 3;
      else if (fn == 6'h26) kind = 4;
    end
    else if (op == 6'h08) kind = 0;
    else if (op == 6'h0C) kind = 2;
    else if (op == 6'h0D) kind = 3;
    else if (op == 6'h0E) kind = 4;
    else if (op == 6'h04) begin kind = 1; br = 1; end
    else if (op == 6'h05) begin kind = 1; br = 2; end
    e.func = (kind < 0) ? 3'd0 : 3'(kind);
    if (kind < 0) begin
      e.result = 8'd0; e.zero = 1'b0; e.sign = 1'b0; e.ovf = 1'b0;
      e.br = 1'b0; e.ill = 1'b1;
      return e;
    end
    if (kind == 0) r = sa + sb;
    else if (kind == 1) r = sa - sb;
    else if (kind == 2) r = int'(a & b);
    else if (kind == 3) r = int'(a | b);
    else r = int'(a ^ b);
    e.result = r[7:0];
    e.zero   = (r[7:0] == 8'd0);
    e.sign   = r[7];
    e.ovf    = (kind <= 1) && ((r > 127) || (r < -128));
    e.br     = (br == 1) ? e.zero : ((br == 2) ? !e.zero : 1'b0);
    e.ill    = 1'b0;
    return e;
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] r, input logic z, input logic s,
                              input logic o, input logic br, input logic ill,
                              input logic [2:0] f);
    vec_t v;
    v.op = op; v.fn = fn; v.a = a; v.b = b;
    v.e.result = r; v.e.zero = z; v.e.sign = s; v.e.ovf = o;
    v.e.br = br; v.e.ill = ill; v.e.func = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input exp_t e);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_result", 32'(bus.rsp_result), 32'(e.result));
    check("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
    check("rsp_sign", 32'(bus.rsp_sign), 32'(e.sign));
    check("rsp_ovf", 32'(bus.rsp_ovf), 32'(e.ovf));
    check("rsp_branch_taken", 32'(bus.rsp_branch_taken), 32'(e.br));
    check("rsp_illegal", 32'(bus.rsp_illegal), 32'(e.ill));
  endtask

  task automatic accept_only(input logic [5:0] op, input logic [5:0] fn,
                             input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.req_opcode = op; bus.req_funct = fn; bus.req_a = a; bus.req_b = b;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [5:0] op, input logic [5:0] fn,
                         input logic [7:0] a, input logic [7:0] b,
                         input exp_t e, input int hold);
    int guard;
    int lat;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    accept_only(op, fn, a, b);
    if (!e.ill) begin
      last_a = a; last_b = b; last_f = e.func;
    end
    check("alu_a", 32'(bus.alu_a), 32'(last_a));
    check("alu_b", 32'(bus.alu_b), 32'(last_b));
    check("alu_function", 32'(bus.alu_function), 32'(last_f));
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), e.ill ? 32'd1 : 32'd2);
    for (int h = 0; h <= hold; h++) begin
      check_rsp(e);
      check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    if (e.ovf && exp_cnt < 255) exp_cnt++;
    check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
    check("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
    check("ovf_count", 32'(bus.ovf_count), 32'(exp_cnt));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ovf_count"}, 32'(bus.ovf_count), 32'd0);
    check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
    check({tag, "_alu_function"}, 32'(bus.alu_function), 32'd0);
    check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
    check({tag, "_rsp_ovf"}, 32'(bus.rsp_ovf), 32'd0);
    check({tag, "_rsp_illegal"}, 32'(bus.rsp_illegal), 32'd0);
    exp_cnt = 0; last_a = 8'd0; last_b = 8'd0; last_f = 3'd0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[17];
    exp_t e;
    logic [5:0] op_pool[8];
    logic [5:0] fn_pool[6];
    logic [5:0] op;
    logic [5:0] fn;
    logic [7:0] a;
    logic [7:0] b;

    tests = 0; fails = 0; exp_cnt = 0;
    last_a = 8'd0; last_b = 8'd0; last_f = 3'd0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_opcode = 6'd0; bus.req_funct = 6'd0;
    bus.req_a = 8'd0; bus.req_b = 8'd0; bus.rsp_ready = 1'b0;

    vecs[0]  = mk(6'h00, 6'h20, 8'd100, 8'd27,  8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[1]  = mk(6'h08, 6'h00, 8'd100, 8'd28,  8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    vecs[2]  = mk(6'h04, 6'h00, 8'd5,   8'd5,   8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    vecs[3]  = mk(6'h05, 6'h00, 8'd5,   8'd5,   8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    vecs[4]  = mk(6'h3F, 6'h00, 8'h12,  8'h34,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    vecs[5]  = mk(6'h00, 6'h22, 8'd3,   8'd5,   8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    vecs[6]  = mk(6'h00, 6'h24, 8'hF0,  8'h3C,  8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    vecs[7]  = mk(6'h00, 6'h25, 8'hF0,  8'h0F,  8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[8]  = mk(6'h00, 6'h26, 8'hAA,  8'hAA,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    vecs[9]  = mk(6'h00, 6'h22, 8'h80,  8'h01,  8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    vecs[10] = mk(6'h00, 6'h21, 8'h01,  8'h02,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    vecs[11] = mk(6'h05, 6'h00, 8'd5,   8'd6,   8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    vecs[12] = mk(6'h0C, 6'h00, 8'hFF,  8'h81,  8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    vecs[13] = mk(6'h0D, 6'h00, 8'h00,  8'h00,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[14] = mk(6'h0E, 6'h00, 8'h7F,  8'h80,  8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4);
    vecs[15] = mk(6'h08, 6'h00, 8'h80,  8'h80,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    vecs[16] = mk(6'h04, 6'h00, 8'h7F,  8'hFF,  8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("reset");

    // Directed table; the first entry also holds rsp_ready low for 5 cycles.
    for (int i = 0; i < 17; i++) begin
      run_txn(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].e,
              (i == 0) ? 5 : (i % 3));
    end

    // Reset while the op is in EXEC.
    accept_only(6'h00, 6'h20, 8'd127, 8'd1);
    check("in_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state("rst_exec");
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Reset while an overflowing response is waiting in RESP.
    accept_only(6'h00, 6'h20, 8'd127, 8'd1);
    @(posedge clk); #1;
    check("resp_pending_valid", 32'(bus.rsp_valid), 32'd1);
    check("resp_pending_ovf", 32'(bus.rsp_ovf), 32'd1);
    pulse_reset();
    check_reset_state("rst_resp");

    // Saturation of the overflow counter.
    e = model(6'h00, 6'h20, 8'd127, 8'd1);
    for (int i = 0; i < 258; i++) run_txn(6'h00, 6'h20, 8'd127, 8'd1, e, 0);
    check("ovf_count_saturated", 32'(bus.ovf_count), 32'd255);
    e = model(6'h3F, 6'h00, 8'd127, 8'd1);
    run_txn(6'h3F, 6'h00, 8'd127, 8'd1, e, 1);
    check("ovf_count_after_illegal", 32'(bus.ovf_count), 32'd255);

    pulse_reset();
    check_reset_state("rst_rand");

    op_pool = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h00};
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00};
    for (int i = 0; i < 300; i++) begin
      op = op_pool[$urandom_range(0, 7)];
      fn = fn_pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      e = model(op, fn, a, b);
      run_txn(op, fn, a, b, e, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
